// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Sole owner of the byte-wide external RAM port. Arbitrates between the
// instruction fetcher (always 32-bit reads) and the load/store buffer
// (1/2/4-byte reads and writes), serialises each access one byte per cycle in
// little-endian order, and returns the assembled word with a one-cycle done
// pulse to the requester that owned the access.
//
// Ports
//   clk_in, rst_in     clock, asynchronous active-high reset
//   rdy_in             global ready; low freezes every register
//   flush              ROB clear; aborts an in-flight read, never a write
//   io_buffer_full     UART buffer full; stalls writes into the IO region
//   mem_din            RAM read byte for the address currently on mem_a
//   mem_dout/mem_a/mem_wr  registered RAM write byte / address / write strobe
//   if_req/if_addr     fetch request (held until if_done) and address
//   if_done/if_data    one-cycle completion pulse and fetched word
//   lsb_req/lsb_wr/lsb_len/lsb_addr/lsb_wdata
//                      LSB request (held until lsb_done), direction, size
//                      (0=byte, 1=half, 2/3=word), address, store data
//   lsb_done/lsb_rdata one-cycle completion pulse and zero-extended load data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_HI  = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  lsb_req,
  input  logic                  lsb_wr,
  input  logic [1:0]            lsb_len,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_done,
  output logic [31:0]           lsb_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSB = 1'b1;

  // Byte count of an LSB access; the reserved size code 3 behaves as a word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Control state (asynchronously reset)
  logic [1:0] state;
  logic [2:0] cnt;
  logic [2:0] n_q;
  logic       owner;
  logic       last_grant;

  // Access payload (loaded on acceptance, no reset needed)
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           buf_q;

  // Acceptance decode
  logic                  accept;
  logic                  grant_lsb;
  logic                  start_wr;
  logic [2:0]            start_n;
  logic [ADDR_WIDTH-1:0] start_addr;

  // Per-byte datapath
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  io_addr;
  logic                  io_stall;
  logic [1:0]            byte_idx;
  logic [31:0]           read_word;
  logic [7:0]            wr_byte;

  // A done pulse in the current cycle forces one idle cycle: the requester
  // still holds its request during that cycle and must not be re-accepted.
  assign accept = (state == S_IDLE) && !flush && !if_done && !lsb_done &&
                  (if_req || lsb_req);

  // On contention the requester that was not served last wins.
  assign grant_lsb  = lsb_req && (!if_req || (last_grant == OWN_IF));
  assign start_addr = grant_lsb ? lsb_addr : if_addr;
  assign start_wr   = grant_lsb && lsb_wr;
  assign start_n    = grant_lsb ? len_to_bytes(lsb_len) : 3'd4;

  // Byte address wraps naturally modulo 2^ADDR_WIDTH.
  assign cur_addr = addr_q + {{(ADDR_WIDTH-3){1'b0}}, cnt};
  assign io_addr  = (addr_q[IO_SEL_HI -: 2] == 2'b11);
  assign io_stall = io_addr && io_buffer_full;

  // Merge the byte arriving this cycle into the partially assembled word.
  // cnt runs 1..N in READ, so byte (cnt-1) is cnt[1:0]-1 modulo 4.
  always_comb begin
    byte_idx  = cnt[1:0] - 2'd1;
    read_word = buf_q;
    read_word[{byte_idx, 3'b000} +: 8] = mem_din;
  end

  // In WRITE cnt is 0..N-1 while a byte remains to be sent.
  assign wr_byte = wdata_q[{cnt[1:0], 3'b000} +: 8];

  // ---- acceptance / byte-serial sequencing ----
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      n_q        <= 3'd0;
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      mem_a      <= '0;
      mem_dout   <= 8'h00;
      mem_wr     <= 1'b0;
      if_done    <= 1'b0;
      lsb_done   <= 1'b0;
      if_data    <= 32'h0;
      lsb_rdata  <= 32'h0;
    end else if (rdy_in) begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner      <= grant_lsb;
            last_grant <= grant_lsb;
            n_q        <= start_n;
            if (start_wr) begin
              // First byte goes out on the next edge, subject to IO stall.
              state <= S_WRITE;
              cnt   <= 3'd0;
            end else begin
              state  <= S_READ;
              mem_a  <= start_addr;
              mem_wr <= 1'b0;
              cnt    <= 3'd1;
            end
          end
        end

        S_READ: begin
          if (flush) begin
            // Speculative read is dropped; nothing is returned.
            state <= S_IDLE;
            mem_a <= '0;
            cnt   <= 3'd0;
          end else if (cnt < n_q) begin
            mem_a <= cur_addr;
            cnt   <= cnt + 3'd1;
          end else begin
            state <= S_IDLE;
            mem_a <= '0;
            cnt   <= 3'd0;
            if (owner == OWN_LSB) begin
              lsb_done  <= 1'b1;
              lsb_rdata <= read_word;
            end else begin
              if_done <= 1'b1;
              if_data <= read_word;
            end
          end
        end

        S_WRITE: begin
          // Stores are already committed, so flush has no effect here.
          if (io_stall) begin
            mem_wr <= 1'b0;
          end else if (cnt < n_q) begin
            mem_wr   <= 1'b1;
            mem_a    <= cur_addr;
            mem_dout <= wr_byte;
            cnt      <= cnt + 3'd1;
          end else begin
            mem_wr   <= 1'b0;
            mem_a    <= '0;
            lsb_done <= 1'b1;
            state    <= S_IDLE;
            cnt      <= 3'd0;
          end
        end

        default: begin
          state  <= S_IDLE;
          mem_wr <= 1'b0;
          cnt    <= 3'd0;
        end
      endcase
    end
  end

  // ---- access payload capture ----
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (accept) begin
        addr_q  <= start_addr;
        wdata_q <= lsb_wdata;
        // Cleared so narrow loads come back zero-extended.
        buf_q   <= 32'h0;
      end else if ((state == S_READ) && !flush) begin
        buf_q <= read_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter: a table of single-requester transactions
// checked for owner, data and latency, followed by hand-written sequences for
// contention, store byte order, IO stall, flush, rdy_in freeze and
// asynchronous reset. A small byte RAM with combinational read sits on the
// memory port.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          flush;
  logic          io_buffer_full;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [31:0]   if_data;
  logic          lsb_req;
  logic          lsb_wr;
  logic [1:0]    lsb_len;
  logic [AW-1:0] lsb_addr;
  logic [31:0]   lsb_wdata;
  logic          lsb_done;
  logic [31:0]   lsb_rdata;

  int checks = 0;
  int errors = 0;

  logic       preload;
  logic [7:0] ram [0:4095];

  mem_arbiter #(.ADDR_WIDTH(AW), .IO_SEL_HI(17)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush          (flush),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .lsb_req        (lsb_req),
    .lsb_wr         (lsb_wr),
    .lsb_len        (lsb_len),
    .lsb_addr       (lsb_addr),
    .lsb_wdata      (lsb_wdata),
    .lsb_done       (lsb_done),
    .lsb_rdata      (lsb_rdata)
  );

  always #5 clk_in = ~clk_in;

  // RAM: byte for the address on mem_a is visible in the same cycle and is
  // sampled by the DUT on the following edge.
  assign mem_din = ram[mem_a[11:0]];

  always @(posedge clk_in) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05;
      ram[12'h102] <= 8'h10; ram[12'h103] <= 8'h00;
      ram[12'h200] <= 8'hA5; ram[12'h201] <= 8'h5A;
      ram[12'h202] <= 8'hC3; ram[12'h203] <= 8'h3C;
      ram[12'h300] <= 8'h78; ram[12'h301] <= 8'h56;
      ram[12'h302] <= 8'h34; ram[12'h303] <= 8'h12;
      ram[12'hFFE] <= 8'h11; ram[12'hFFF] <= 8'h22;
      ram[12'h000] <= 8'h33; ram[12'h001] <= 8'h44;
    end else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
    end
  end

  typedef struct {
    logic        is_lsb;
    logic        wr;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 10;
  vec_t tbl [NVEC];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    lsb_req   = 1'b0;
    lsb_wr    = 1'b0;
    lsb_len   = 2'd0;
    if_addr   = '0;
    lsb_addr  = '0;
    lsb_wdata = 32'h0;
  endtask

  // One transaction from a single requester; waits (bounded) for done.
  task automatic run_txn(input string tag, input vec_t v);
    int  lat;
    logic seen;
    lat  = 0;
    seen = 1'b0;
    if (v.is_lsb) begin
      lsb_req   = 1'b1;
      lsb_wr    = v.wr;
      lsb_len   = v.len;
      lsb_addr  = v.addr;
      lsb_wdata = v.wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    while (!seen && lat < 20) begin
      step();
      lat++;
      if (if_done || lsb_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, lat);
    end else begin
      chk({tag, " owner"}, {30'h0, if_done, lsb_done}, {30'h0, !v.is_lsb, v.is_lsb});
      chk({tag, " latency"}, lat, v.exp_lat);
      if (!v.wr) chk({tag, " data"}, v.is_lsb ? lsb_rdata : if_data, v.exp_data);
    end
    idle_inputs();
    step();
    chk({tag, " single pulse"}, {30'h0, if_done, lsb_done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          is_lsb wr    len   addr          wdata         exp_data      lat
    tbl[0] = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,        32'h0010_0513, 5};
    tbl[1] = '{1'b1, 1'b0, 2'd0, 32'h0000_0201, 32'h0,        32'h0000_005A, 2};
    tbl[2] = '{1'b1, 1'b0, 2'd1, 32'h0000_0202, 32'h0,        32'h0000_3CC3, 3};
    tbl[3] = '{1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'h0,        32'h1234_5678, 5};
    tbl[4] = '{1'b1, 1'b0, 2'd3, 32'h0000_0200, 32'h0,        32'h3CC3_5AA5, 5};
    tbl[5] = '{1'b1, 1'b1, 2'd0, 32'h0000_0600, 32'hFFFF_FF9E, 32'h0,        3};
    tbl[6] = '{1'b1, 1'b0, 2'd2, 32'h0000_0600, 32'h0,        32'h0000_009E, 5};
    tbl[7] = '{1'b1, 1'b1, 2'd2, 32'h0000_0604, 32'hCAFE_F00D, 32'h0,        6};
    tbl[8] = '{1'b1, 1'b0, 2'd1, 32'h0000_0606, 32'h0,        32'h0000_CAFE, 3};
    tbl[9] = '{1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,        32'h4433_2211, 5};

    rst_in         = 1'b1;
    preload        = 1'b1;
    rdy_in         = 1'b1;
    flush          = 1'b0;
    io_buffer_full = 1'b0;
    idle_inputs();
    step();
    step();
    chk("reset mem_a", mem_a, 32'h0);
    chk("reset mem_wr/dout", {23'h0, mem_wr, mem_dout}, 32'h0);
    chk("reset done", {30'h0, if_done, lsb_done}, 32'h0);
    chk("reset if_data", if_data, 32'h0);
    chk("reset lsb_rdata", lsb_rdata, 32'h0);
    rst_in  = 1'b0;
    preload = 1'b0;
    step();

    for (int i = 0; i < NVEC; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Word fetch: byte addresses on consecutive cycles.
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("fetch mem_a%0d", k), mem_a, 32'h100 + k);
      chk($sformatf("fetch no early done%0d", k), {31'h0, if_done}, 32'h0);
    end
    step();
    chk("fetch done", {31'h0, if_done}, 32'h1);
    chk("fetch data", if_data, 32'h0010_0513);
    chk("fetch mem_a back to 0", mem_a, 32'h0);
    idle_inputs();
    step();
    chk("fetch pulse ends", {31'h0, if_done}, 32'h0);

    // Contention, last grant = IF (table ended with a fetch): LSB first.
    if_req = 1'b1; if_addr = 32'h100;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h200;
    step();
    chk("contA first grant", mem_a, 32'h200);
    step();
    chk("contA lsb done", {30'h0, if_done, lsb_done}, 32'h1);
    chk("contA lsb data", lsb_rdata, 32'h0000_00A5);
    lsb_req = 1'b0;
    step();
    chk("contA idle cycle mem_a", mem_a, 32'h0);
    chk("contA idle cycle done", {30'h0, if_done, lsb_done}, 32'h0);
    step();
    chk("contA second grant", mem_a, 32'h100);
    for (int k = 0; k < 4; k++) step();
    chk("contA if done", {30'h0, if_done, lsb_done}, 32'h2);
    chk("contA if data", if_data, 32'h0010_0513);
    idle_inputs();
    step();

    // Make LSB the last grant, then contend again: fetch first.
    run_txn("prep", '{1'b1, 1'b0, 2'd0, 32'h203, 32'h0, 32'h3C, 2});
    if_req = 1'b1; if_addr = 32'h300;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h200;
    step();
    chk("contB first grant", mem_a, 32'h300);
    for (int k = 0; k < 4; k++) step();
    chk("contB if done", {30'h0, if_done, lsb_done}, 32'h2);
    chk("contB if data", if_data, 32'h1234_5678);
    if_req = 1'b0;
    step();
    chk("contB idle cycle", mem_a, 32'h0);
    step();
    chk("contB second grant", mem_a, 32'h200);
    step();
    chk("contB lsb done", {30'h0, if_done, lsb_done}, 32'h1);
    chk("contB lsb data", lsb_rdata, 32'h0000_00A5);
    idle_inputs();
    step();

    // Half store, little-endian byte order.
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd1;
    lsb_addr = 32'h400; lsb_wdata = 32'hDEAD_BEEF;
    step();
    chk("hst accept no write", {31'h0, mem_wr}, 32'h0);
    step();
    chk("hst byte0", {mem_wr, mem_a[11:0], mem_dout}, {1'b1, 12'h400, 8'hEF});
    step();
    chk("hst byte1", {mem_wr, mem_a[11:0], mem_dout}, {1'b1, 12'h401, 8'hBE});
    step();
    chk("hst done", {30'h0, mem_wr, lsb_done}, 32'h1);
    idle_inputs();
    step();
    run_txn("hst readback", '{1'b1, 1'b0, 2'd2, 32'h400, 32'h0, 32'h0000_BEEF, 5});

    // IO stall: byte store to the IO region with the UART buffer full.
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd0;
    lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0000_0077;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("io stall%0d", k), {30'h0, mem_wr, lsb_done}, 32'h0);
    end
    io_buffer_full = 1'b0;
    step();
    chk("io write", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h0003_0000, 8'h77});
    step();
    chk("io done", {30'h0, mem_wr, lsb_done}, 32'h1);
    idle_inputs();
    step();

    // Flush during the third byte of a fetch.
    if_req = 1'b1; if_addr = 32'h300;
    step(); step(); step();
    chk("flush before", mem_a, 32'h302);
    flush = 1'b1;
    step();
    chk("flush abort mem_a", mem_a, 32'h0);
    chk("flush no done", {31'h0, if_done}, 32'h0);
    flush = 1'b0;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("flush quiet%0d", k), {30'h0, if_done, lsb_done}, 32'h0);
    end
    run_txn("after flush", '{1'b0, 1'b0, 2'd2, 32'h300, 32'h0, 32'h1234_5678, 5});

    // Flush during a word store is ignored.
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd2;
    lsb_addr = 32'h500; lsb_wdata = 32'h1122_3344;
    step(); step();
    flush = 1'b1;
    step(); step();
    flush = 1'b0;
    step();
    chk("fst not yet done", {31'h0, lsb_done}, 32'h0);
    step();
    chk("fst done", {31'h0, lsb_done}, 32'h1);
    idle_inputs();
    step();
    run_txn("fst readback", '{1'b1, 1'b0, 2'd2, 32'h500, 32'h0, 32'h1122_3344, 5});

    // rdy_in low for two cycles mid-load.
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd2; lsb_addr = 32'h100;
    step(); step();
    chk("rdy pre", mem_a, 32'h101);
    rdy_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("rdy frozen mem_a%0d", k), mem_a, 32'h101);
      chk($sformatf("rdy frozen done%0d", k), {31'h0, lsb_done}, 32'h0);
    end
    rdy_in = 1'b1;
    step(); step();
    chk("rdy not yet done", {31'h0, lsb_done}, 32'h0);
    step();
    chk("rdy done", {31'h0, lsb_done}, 32'h1);
    chk("rdy data", lsb_rdata, 32'h0010_0513);
    idle_inputs();
    step();

    // Asynchronous reset mid-fetch clears outputs without a clock edge.
    if_req = 1'b1; if_addr = 32'h100;
    step(); step();
    rst_in = 1'b1;
    #1;
    chk("arst mem_a", mem_a, 32'h0);
    chk("arst mem_wr/dout", {23'h0, mem_wr, mem_dout}, 32'h0);
    chk("arst data", if_data | lsb_rdata, 32'h0);
    chk("arst done", {30'h0, if_done, lsb_done}, 32'h0);
    idle_inputs();
    step();
    rst_in = 1'b0;
    step();
    run_txn("post reset", '{1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h0010_0513, 5});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
